// File: rtl/af_trig_sequencer.sv
// Auto-focus trigger sequencer: synchronised trigger edges start a lens
// settle hold-off, after which auto-focus is requested until manual, timeout or retrigger.
module af_trig_sequencer #(
    parameter int unsigned N_TRIG         = 2,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned HOLD_CYCLES    = 2950000,
    parameter int unsigned ACTIVE_TIMEOUT = 0,
    parameter bit          PULSE_MODE     = 1'b0,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_TRIG-1:0] i_trig,
    input  logic [N_TRIG-1:0] i_trig_en,
    input  logic              i_foc_enable,
    output logic              o_auto_focus_trig,
    output logic              o_auto_focus_active,
    output logic              o_holdoff_busy,
    output logic              o_af_timeout,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_ACTIVE = 2'd2,
        S_MANUAL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACTIVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               HAS_TMO   = (ACTIVE_TIMEOUT != 0);

    logic [N_TRIG-1:0]      r_trig_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_foc_sync;
    logic [SYNC_STAGES-1:0] r_settle;
    logic [N_TRIG-1:0]      r_trig_prev;
    logic [N_TRIG-1:0]      r_arm;
    logic                   r_ev;

    logic [N_TRIG-1:0]      w_trig_s;
    logic [N_TRIG-1:0]      w_trig_edge;
    logic                   w_foc_s;

    assign w_trig_s    = r_trig_sync[SYNC_STAGES-1];
    assign w_foc_s     = r_foc_sync[SYNC_STAGES-1];
    // A source only arms once it has been seen low after reset, so a
    // level already high when reset releases is not taken as an edge.
    assign w_trig_edge = w_trig_s & ~r_trig_prev & r_arm;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_trig_sync[i] <= '0;
            end
            r_foc_sync  <= '0;
            r_settle    <= '0;
            r_trig_prev <= '0;
            r_arm       <= '0;
            r_ev        <= 1'b0;
        end else begin
            r_trig_sync[0] <= i_trig;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_trig_sync[i] <= r_trig_sync[i-1];
            end
            r_foc_sync  <= {r_foc_sync[SYNC_STAGES-2:0], i_foc_enable};
            r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_trig_prev <= w_trig_s;
            if (r_settle[SYNC_STAGES-1]) begin
                r_arm <= r_arm | ~w_trig_s;
            end
            r_ev <= |(w_trig_edge & i_trig_en);
        end
    end

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_acnt;
    logic             w_hold_done;
    logic             w_act_done;
    logic             w_timeout;
    logic             r_af_trig;
    logic             r_af_active;
    logic             r_busy;
    logic             r_tmo;

    assign w_hold_done = (r_hcnt == HOLD_LAST);
    assign w_act_done  = HAS_TMO && (r_acnt == ACT_LAST);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_foc_s) begin
                    w_next = S_MANUAL;
                end else if (r_ev) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_foc_s) begin
                    w_next = S_MANUAL;
                end else if (r_ev) begin
                    w_next = S_HOLD;
                end else if (w_hold_done) begin
                    w_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_foc_s) begin
                    w_next = S_MANUAL;
                end else if (r_ev) begin
                    w_next = S_HOLD;
                end else if (w_act_done) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_MANUAL: begin
                if (!w_foc_s) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_hcnt      <= '0;
            r_acnt      <= '0;
            r_af_trig   <= 1'b0;
            r_af_active <= 1'b0;
            r_busy      <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counters clear outside their state and on retrigger.
            r_hcnt  <= (r_state == S_HOLD && !r_ev) ? r_hcnt + CNT_ONE : '0;
            if (r_state != S_ACTIVE) begin
                r_acnt <= '0;
            end else if (r_acnt != '1) begin
                r_acnt <= r_acnt + CNT_ONE;
            end
            r_af_active <= (w_next == S_ACTIVE);
            r_busy      <= (w_next == S_HOLD);
            r_tmo       <= w_timeout;
            if (PULSE_MODE) begin
                r_af_trig <= (w_next == S_ACTIVE) && (r_state != S_ACTIVE);
            end else begin
                r_af_trig <= (w_next == S_ACTIVE);
            end
        end
    end

    assign o_auto_focus_trig   = r_af_trig;
    assign o_auto_focus_active = r_af_active;
    assign o_holdoff_busy      = r_busy;
    assign o_af_timeout        = r_tmo;
    assign o_state             = r_state;

endmodule
